// File: rtl/shifter_pkg.sv
// Shared shift-unit definitions: shift-type encoding (common with the
// single-cycle barrel shifter) and the iterative shifter's FSM states.
package shifter_pkg;

  localparam logic [1:0] SHT_SRL     = 2'd0;
  localparam logic [1:0] SHT_SLL     = 2'd1;
  localparam logic [1:0] SHT_SRA     = 2'd2;
  localparam logic [1:0] SHT_SLL_ALT = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to hold a shift amount for a given operand width.
  function automatic int shamt_bits(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Start/done request bus of the iterative shifter. The requester (ALU
// control) uses the master modport; the shift unit uses the slave modport.
// The type field is named sh_type because "type" is a reserved word.
interface seq_shifter_if #(
  parameter int WIDTH = 32
);
  localparam int SW = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [SW-1:0]    shamt;
  logic [1:0]       sh_type;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] r;

  modport master (
    output start, a, shamt, sh_type,
    input  busy, done, r
  );

  modport slave (
    input  start, a, shamt, sh_type,
    output busy, done, r
  );

endinterface

// File: rtl/seq_shifter_shift_step.sv
// One combinational shift step of the iterative shifter: shifts acc by
// step positions (1, or 4 when SEQ_SHIFTER_FAST_EN is built in).
// Arithmetic right shifts fill every vacated bit with the sign bit.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       op,
  input  logic [2:0]       step,
  output logic [WIDTH-1:0] acc_next
);

  logic signed [WIDTH-1:0] acc_s;

  assign acc_s = signed'(acc);

  // Select the shift direction and fill for this operation.
  always_comb begin
    acc_next = acc;
    case (op)
      SHT_SRL: acc_next = acc >> step;
      SHT_SRA: acc_next = unsigned'(acc_s >>> step);
      default: acc_next = acc << step;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Iterative srl/sll/sra unit with a start/done handshake. One shift step
// per cycle; with SEQ_SHIFTER_FAST_EN defined, steps of 4 are taken while
// at least 4 positions remain. Results match in both builds.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  seq_shifter_if.slave bus
);

  localparam int SW = shamt_bits(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [SW-1:0]    cnt;
  logic [1:0]       op;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] r_q;
  logic             done_q;
  logic [2:0]       step;
  logic             load;
  logic             advance;
  logic             finish;

`ifdef SEQ_SHIFTER_FAST_EN
  assign step = (cnt >= SW'(4)) ? 3'd4 : 3'd1;
`else
  assign step = 3'd1;
`endif

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc      (acc),
    .op       (op),
    .step     (step),
    .acc_next (acc_next)
  );

  // Next-state and step-control decode.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control state: FSM, remaining count, operation, done pulse, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op     <= SHT_SRL;
      done_q <= 1'b0;
      r_q    <= '0;
    end else begin
      state  <= state_next;
      done_q <= finish;
      if (load) begin
        cnt <= bus.shamt;
        op  <= bus.sh_type;
      end else if (advance) begin
        cnt <= cnt - SW'(step);
      end
      if (finish) begin
        r_q <= acc;
      end
    end
  end

  // Working register: loaded on accept, shifted on every active step.
  always_ff @(posedge clk) begin
    if (load) begin
      acc <= bus.a;
    end else if (advance) begin
      acc <= acc_next;
    end
  end

  assign bus.busy = (state == ST_SHIFT);
  assign bus.done = done_q;
  assign bus.r    = r_q;

endmodule
